// File: rtl/bf_cfg_pipe_if.sv
// Transaction bundle for bf_cfg_pipe: operand/mode input beat and result output beat.
// The master drives the input beat and out_ready; the slave (the butterfly) drives the rest.
interface bf_cfg_pipe_if #(
    parameter int DATA_WIDTH = 256
);
    logic                  in_valid;
    logic                  in_ready;
    logic [1:0]            mode;
    logic [DATA_WIDTH-1:0] a_i;
    logic [DATA_WIDTH-1:0] b_i;
    logic [DATA_WIDTH-1:0] omg;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] a_o;
    logic [DATA_WIDTH-1:0] b_o;

    // Handshake: a beat transfers on a rising clk edge where valid & ready are both high;
    // the sender keeps valid and payload stable until that edge, ready may change freely.
    modport master (
        output in_valid, mode, a_i, b_i, omg, out_ready,
        input  in_ready, out_valid, a_o, b_o
    );

    modport slave (
        input  in_valid, mode, a_i, b_i, omg, out_ready,
        output in_ready, out_valid, a_o, b_o
    );
endinterface

// File: rtl/bf_cfg_pipe.sv
// Four-mode modular butterfly (CT NTT, GS INTT with halving, PWM, bypass), MM_LAT+2 stage stall pipe.
// Optional macro BF_RANGE_CHECK_EN adds a sticky range_err output for out-of-range operands.
module bf_cfg_pipe #(
    parameter int                    DATA_WIDTH = 256,
    parameter int                    MM_LAT     = 6,
    parameter logic [DATA_WIDTH-1:0] M          = DATA_WIDTH'({1'b0, {247{1'b1}}, 8'hED})
) (
    input logic          clk,
    input logic          rst,
    bf_cfg_pipe_if.slave bf
`ifdef BF_RANGE_CHECK_EN
    ,
    output logic         range_err
`endif
);
    localparam logic [DATA_WIDTH-1:0] M_HALF = (M >> 1) + DATA_WIDTH'(1);
    localparam logic [1:0] MODE_CT  = 2'b00;
    localparam logic [1:0] MODE_GS  = 2'b01;
    localparam logic [1:0] MODE_PWM = 2'b10;
    localparam logic [1:0] MODE_BYP = 2'b11;

    function automatic logic [DATA_WIDTH-1:0] mod_add(input logic [DATA_WIDTH-1:0] x,
                                                      input logic [DATA_WIDTH-1:0] y);
        logic [DATA_WIDTH:0] s;
        s = {1'b0, x} + {1'b0, y};
        if (s >= {1'b0, M}) s = s - {1'b0, M};
        return s[DATA_WIDTH-1:0];
    endfunction

    // Wraps modulo 2^DATA_WIDTH when x<y; adding M brings it back into [0, M).
    function automatic logic [DATA_WIDTH-1:0] mod_sub(input logic [DATA_WIDTH-1:0] x,
                                                      input logic [DATA_WIDTH-1:0] y);
        if (x < y) return x + M - y;
        return x - y;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] mod_mul(input logic [DATA_WIDTH-1:0] x,
                                                      input logic [DATA_WIDTH-1:0] y);
        logic [2*DATA_WIDTH-1:0] prod;
        prod = {{DATA_WIDTH{1'b0}}, x} * {{DATA_WIDTH{1'b0}}, y};
        return DATA_WIDTH'(prod % {{DATA_WIDTH{1'b0}}, M});
    endfunction

    function automatic logic [DATA_WIDTH-1:0] mod_half(input logic [DATA_WIDTH-1:0] v);
        if (v[0]) return (v >> 1) + M_HALF;
        return v >> 1;
    endfunction

    logic                  adv;
    logic                  out_v_q;
    logic [DATA_WIDTH-1:0] a_q, b_q, q_a_d, q_b_d;

    logic                  p_v_q;
    logic [1:0]            p_mode_q;
    logic [DATA_WIDTH-1:0] p_x_q, p_m1_q, p_m2_q;
    logic [DATA_WIDTH-1:0] p_x_d, p_m1_d, p_m2_d;

    logic                  mul_v_q    [MM_LAT];
    logic [1:0]            mul_mode_q [MM_LAT];
    logic [DATA_WIDTH-1:0] mul_x_q    [MM_LAT];
    logic [DATA_WIDTH-1:0] mul_p_q    [MM_LAT];
    logic [DATA_WIDTH-1:0] mul_p_d;

    // Whole pipe moves in lockstep; bubbles travel like data so latency is fixed.
    assign adv         = ~out_v_q | bf.out_ready;
    assign bf.in_ready = adv;

    always_comb begin
        p_x_d  = bf.a_i;
        p_m1_d = bf.b_i;
        p_m2_d = bf.omg;
        case (bf.mode)
            MODE_CT: ;
            MODE_GS: begin
                p_x_d  = mod_add(bf.a_i, bf.b_i);
                p_m1_d = mod_sub(bf.a_i, bf.b_i);
            end
            MODE_PWM: begin
                p_x_d  = '0;
                p_m1_d = bf.a_i;
                p_m2_d = bf.b_i;
            end
            MODE_BYP: p_m2_d = DATA_WIDTH'(1);
        endcase
    end

    assign mul_p_d = mod_mul(p_m1_q, p_m2_q);

    always_comb begin
        q_a_d = mul_x_q[MM_LAT-1];
        q_b_d = mul_p_q[MM_LAT-1];
        case (mul_mode_q[MM_LAT-1])
            MODE_CT: begin
                q_a_d = mod_add(mul_x_q[MM_LAT-1], mul_p_q[MM_LAT-1]);
                q_b_d = mod_sub(mul_x_q[MM_LAT-1], mul_p_q[MM_LAT-1]);
            end
            MODE_GS: begin
                q_a_d = mod_half(mul_x_q[MM_LAT-1]);
                q_b_d = mod_half(mul_p_q[MM_LAT-1]);
            end
            MODE_PWM: begin
                q_a_d = mul_p_q[MM_LAT-1];
                q_b_d = '0;
            end
            MODE_BYP: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_v_q    <= 1'b0;
            p_mode_q <= 2'b00;
            p_x_q    <= '0;
            p_m1_q   <= '0;
            p_m2_q   <= '0;
            for (int i = 0; i < MM_LAT; i++) begin
                mul_v_q[i]    <= 1'b0;
                mul_mode_q[i] <= 2'b00;
                mul_x_q[i]    <= '0;
                mul_p_q[i]    <= '0;
            end
            out_v_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
        end else if (adv) begin
            p_v_q         <= bf.in_valid;
            p_mode_q      <= bf.mode;
            p_x_q         <= p_x_d;
            p_m1_q        <= p_m1_d;
            p_m2_q        <= p_m2_d;
            mul_v_q[0]    <= p_v_q;
            mul_mode_q[0] <= p_mode_q;
            mul_x_q[0]    <= p_x_q;
            mul_p_q[0]    <= mul_p_d;
            for (int i = 1; i < MM_LAT; i++) begin
                mul_v_q[i]    <= mul_v_q[i-1];
                mul_mode_q[i] <= mul_mode_q[i-1];
                mul_x_q[i]    <= mul_x_q[i-1];
                mul_p_q[i]    <= mul_p_q[i-1];
            end
            out_v_q <= mul_v_q[MM_LAT-1];
            a_q     <= q_a_d;
            b_q     <= q_b_d;
        end
    end

    assign bf.out_valid = out_v_q;
    assign bf.a_o       = a_q;
    assign bf.b_o       = b_q;

`ifdef BF_RANGE_CHECK_EN
    logic range_err_q;

    // Twiddle is only meaningful in CT/GS, so it is range-checked only there.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            range_err_q <= 1'b0;
        end else if (bf.in_valid && adv &&
                     (bf.a_i >= M || bf.b_i >= M || (!bf.mode[1] && bf.omg >= M))) begin
            range_err_q <= 1'b1;
        end
    end

    assign range_err = range_err_q;
`endif
endmodule

// File: tb/tb_bf_cfg_pipe.sv
// Directed bench for bf_cfg_pipe: 64-bit modulus, MM_LAT=6, immediate assertions at every check point.
module tb_bf_cfg_pipe;
    localparam int          DW  = 64;
    localparam int          LAT = 6;
    localparam logic [63:0] MOD = 64'hFFFF_FFFF_0000_0001;
    localparam logic [127:0] MODW = {64'd0, MOD};

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_assert = 0;
    int   n_fail = 0;
    int   stall_lo = -1;
    int   stall_hi = -1;
    logic [63:0] held_a, held_b;
    logic [DW-1:0] exp_a_q[$];
    logic [DW-1:0] exp_b_q[$];
    logic [63:0] got_a[$];
    logic [63:0] got_b[$];
    int          got_cyc[$];

    bf_cfg_pipe_if #(.DATA_WIDTH(DW)) bus ();

`ifdef BF_RANGE_CHECK_EN
    logic range_err;
`endif

    bf_cfg_pipe #(
        .DATA_WIDTH(DW),
        .MM_LAT    (LAT),
        .M         (MOD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bf (bus)
`ifdef BF_RANGE_CHECK_EN
        ,
        .range_err(range_err)
`endif
    );

    // clock/reset block
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Result collector: a beat is taken at the next rising edge when valid & ready.
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            got_a.push_back(bus.a_o);
            got_b.push_back(bus.b_o);
            got_cyc.push_back(cyc);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no end of test, required end before 200000");
        $fatal(1, "watchdog expired");
    end

    // reference model (wide arithmetic with % rather than conditional correction)
    function automatic logic [63:0] madd(input logic [63:0] x, input logic [63:0] y);
        logic [127:0] t;
        t = ({64'd0, x} + {64'd0, y}) % MODW;
        return t[63:0];
    endfunction

    function automatic logic [63:0] msub(input logic [63:0] x, input logic [63:0] y);
        logic [127:0] t;
        t = ({64'd0, x} + MODW - {64'd0, y}) % MODW;
        return t[63:0];
    endfunction

    function automatic logic [63:0] mmul(input logic [63:0] x, input logic [63:0] y);
        logic [127:0] t;
        t = ({64'd0, x} * {64'd0, y}) % MODW;
        return t[63:0];
    endfunction

    function automatic logic [63:0] mhalf(input logic [63:0] v);
        logic [127:0] t;
        t = {64'd0, v};
        if (v[0]) t = t + MODW;
        t = t >> 1;
        return t[63:0];
    endfunction

    task automatic ref_bf(input logic [1:0] m, input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] w, output logic [63:0] ea, output logic [63:0] eb);
        case (m)
            2'b00: begin ea = madd(a, mmul(b, w)); eb = msub(a, mmul(b, w)); end
            2'b01: begin ea = mhalf(madd(a, b)); eb = mhalf(mmul(msub(a, b), w)); end
            2'b10: begin ea = mmul(a, b); eb = 64'd0; end
            default: begin ea = a; eb = b; end
        endcase
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // One cycle: advance past the edge, set out_ready for the next edge, then check stall behaviour.
    task automatic tick();
        @(posedge clk);
        #1;
        bus.out_ready = !(cyc >= stall_lo && cyc < stall_hi);
        #1;
        if (cyc == stall_lo) begin
            held_a = bus.a_o;
            held_b = bus.b_o;
        end
        if (cyc >= stall_lo && cyc < stall_hi) begin
            chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
            chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
        end
        if (cyc > stall_lo && cyc <= stall_hi) begin
            chk("bp_a_hold", bus.a_o, held_a);
            chk("bp_b_hold", bus.b_o, held_b);
        end
    endtask

    // driver: present one beat and hold it until accepted
    task automatic send(input logic [1:0] m, input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] w);
        logic acc;
        int   n;
        bus.in_valid = 1'b1;
        bus.mode     = m;
        bus.a_i      = a;
        bus.b_i      = b;
        bus.omg      = w;
        n = 0;
        do begin
            acc = bus.in_ready;
            tick();
            n++;
        end while (!acc && n < 50);
        if (!acc) chk("send_accept", 64'(acc), 64'd1);
        bus.in_valid = 1'b0;
    endtask

    task automatic run_single(input string tag, input logic [1:0] m, input logic [63:0] a,
                              input logic [63:0] b, input logic [63:0] w,
                              input logic [63:0] ea, input logic [63:0] eb);
        send(m, a, b, w);
        repeat (LAT) tick();
        chk({tag, "_early"}, 64'(bus.out_valid), 64'd0);
        tick();
        chk({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
        chk({tag, "_a"}, bus.a_o, ea);
        chk({tag, "_b"}, bus.b_o, eb);
        tick();
        chk({tag, "_drain"}, 64'(bus.out_valid), 64'd0);
    endtask

    task automatic rand_beat(output logic [1:0] m, output logic [63:0] a,
                             output logic [63:0] b, output logic [63:0] w);
        m = 2'($urandom_range(0, 3));
        a = {$urandom, $urandom}; a[63] = 1'b0;
        b = {$urandom, $urandom}; b[63] = 1'b0;
        w = {$urandom, $urandom}; w[63] = 1'b0;
    endtask

    task automatic check_stream(input string tag, input int base, input int start);
        int n;
        n = 0;
        while (got_a.size() - base < 20 && n < 200) begin
            tick();
            n++;
        end
        chk({tag, "_count"}, 64'(got_a.size() - base), 64'd20);
        for (int i = 0; i < 20; i++) begin
            if (base + i < got_a.size()) begin
                chk({tag, "_a"}, got_a[base+i], exp_a_q[i]);
                chk({tag, "_b"}, got_b[base+i], exp_b_q[i]);
            end
        end
        if (start >= 0 && got_a.size() - base >= 20) begin
            chk({tag, "_first_cyc"}, 64'(got_cyc[base] - start), 64'd8);
            chk({tag, "_contig"}, 64'(got_cyc[base+19] - got_cyc[base]), 64'd19);
        end
        exp_a_q.delete();
        exp_b_q.delete();
    endtask

    initial begin
        logic [1:0]  m;
        logic [63:0] a, b, w, ea, eb;
        int          base, start;

        bus.in_valid  = 1'b0;
        bus.mode      = 2'b00;
        bus.a_i       = '0;
        bus.b_i       = '0;
        bus.omg       = '0;
        bus.out_ready = 1'b1;
        rst           = 1'b1;
        #1;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_a_o", bus.a_o, 64'd0);
        chk("rst_b_o", bus.b_o, 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;

        run_single("ct", 2'b00, 64'd5, 64'd3, 64'd2, 64'd11, 64'hFFFF_FFFF_0000_0000);
        run_single("gs1", 2'b01, 64'd4, 64'd1, 64'd1,
                   64'h7FFF_FFFF_8000_0003, 64'h7FFF_FFFF_8000_0002);
        run_single("gs2", 2'b01, 64'd5, 64'd3, 64'd4, 64'd4, 64'd4);
        run_single("pwm", 2'b10, MOD - 64'd1, MOD - 64'd1, 64'd123, 64'd1, 64'd0);
        run_single("byp", 2'b11, 64'd7, 64'd9, 64'd55, 64'd7, 64'd9);

        // back-to-back mixed modes, no backpressure
        base  = got_a.size();
        start = cyc;
        for (int i = 0; i < 20; i++) begin
            rand_beat(m, a, b, w);
            ref_bf(m, a, b, w, ea, eb);
            exp_a_q.push_back(ea);
            exp_b_q.push_back(eb);
            send(m, a, b, w);
        end
        check_stream("s4", base, start);

        // five-cycle out_ready stall once the pipe is full
        base     = got_a.size();
        stall_lo = cyc + 10;
        stall_hi = stall_lo + 5;
        for (int i = 0; i < 20; i++) begin
            rand_beat(m, a, b, w);
            ref_bf(m, a, b, w, ea, eb);
            exp_a_q.push_back(ea);
            exp_b_q.push_back(eb);
            send(m, a, b, w);
        end
        check_stream("s5", base, -1);
        stall_lo = -1;
        stall_hi = -1;

        // reset with a result on the output and several beats in flight
        for (int i = 0; i < 10; i++) begin
            rand_beat(m, a, b, w);
            send(m, a, b, w);
        end
        chk("pre_rst_valid", 64'(bus.out_valid), 64'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("mid_rst_a_o", bus.a_o, 64'd0);
        chk("mid_rst_b_o", bus.b_o, 64'd0);
        @(posedge clk);
        #2;
        rst  = 1'b0;
        base = got_a.size();
        repeat (10) begin
            tick();
            chk("post_rst_quiet", 64'(bus.out_valid), 64'd0);
        end
        chk("post_rst_no_result", 64'(got_a.size() - base), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
